// File: rtl/apb_target_mux_pkg.sv
// Shared types for the APB target multiplexer: FSM state and the APB request/response
// bundles used by apb_processor and the peripheral targets.
package apb_target_mux_pkg;

    localparam int MAX_TARGETS = 16;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    typedef struct packed {
        logic [31:0] paddr;
        logic        penable;
        logic        psel;
        logic        pwrite;
        logic [31:0] pwdata;
    } apb_request_t;

    typedef struct packed {
        logic [31:0] prdata;
        logic        pready;
        logic        perr;
    } apb_response_t;

    function automatic apb_response_t error_response();
        apb_response_t r;
        r.prdata = 32'h0;
        r.pready = 1'b1;
        r.perr   = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/apb_timeout_counter.sv
// Saturating wait-state counter; expired flags that the target has stalled for the full
// timeout budget. A TIMEOUT_CYCLES of 0 never expires.
module apb_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic clk,
    input  logic clk_enable,
    input  logic reset_n,
    input  logic clear,
    input  logic increment,
    output logic expired
);

    localparam int W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYCLES);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clk_enable) begin
            if (clear) begin
                count <= '0;
            end else if (increment && (count != LIMIT)) begin
                count <= count + W'(1);
            end
        end
    end

    assign expired = (TIMEOUT_CYCLES != 0) && (count == LIMIT);

endmodule

// File: rtl/apb_target_mux.sv
// N-way APB address decoder and response multiplexer. The select field of paddr picks a
// target in the setup phase; that choice is held for the whole access phase.
module apb_target_mux
    import apb_target_mux_pkg::*;
#(
    parameter int NUM_TARGETS    = 4,
    parameter int SEL_HI         = 31,
    parameter int SEL_LO         = 28,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                     clk,
    input  logic                     clk__enable,
    input  logic                     reset_n,
    input  logic [31:0]              apb_request__paddr,
    input  logic                     apb_request__penable,
    input  logic                     apb_request__psel,
    input  logic                     apb_request__pwrite,
    input  logic [31:0]              apb_request__pwdata,
    output logic [31:0]              apb_response__prdata,
    output logic                     apb_response__pready,
    output logic                     apb_response__perr,
    output logic [NUM_TARGETS-1:0]   tgt_psel,
    input  logic [32*NUM_TARGETS-1:0] tgt_prdata,
    input  logic [NUM_TARGETS-1:0]   tgt_pready,
    input  logic [NUM_TARGETS-1:0]   tgt_perr,
    output logic                     error_pulse,
    output logic                     error_timeout,
    output logic [31:0]              error_addr
);

    localparam int SW = SEL_HI - SEL_LO + 1;

    state_t        state, next_state;
    logic [3:0]    tgt_idx;
    logic          tgt_mapped;
    logic [SW-1:0] live_field;
    logic [3:0]    live_idx;
    logic          live_mapped;
    logic          setup;
    logic          expired;
    logic          cnt_inc;
    logic          timeout_fire;
    logic          err_done;
    logic          sel_active;
    logic [3:0]    sel_idx;
    apb_response_t resp;

    logic [31:0] rd_arr  [MAX_TARGETS];
    logic        rdy_arr [MAX_TARGETS];
    logic        err_arr [MAX_TARGETS];

    // Write direction is broadcast to targets outside this block.
    logic unused_inputs;
    assign unused_inputs = ^{apb_request__pwrite, apb_request__pwdata};

    assign live_field  = apb_request__paddr[SEL_HI:SEL_LO];
    assign live_idx    = 4'(live_field);
    assign live_mapped = 32'(live_field) < 32'(NUM_TARGETS);
    assign setup       = apb_request__psel && !apb_request__penable;

    for (genvar g = 0; g < MAX_TARGETS; g++) begin : g_resp
        if (g < NUM_TARGETS) begin : g_used
            assign rd_arr[g]  = tgt_prdata[32*g +: 32];
            assign rdy_arr[g] = tgt_pready[g];
            assign err_arr[g] = tgt_perr[g];
        end else begin : g_unused
            assign rd_arr[g]  = 32'h0;
            assign rdy_arr[g] = 1'b0;
            assign err_arr[g] = 1'b0;
        end
    end

    apb_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk        (clk),
        .clk_enable (clk__enable),
        .reset_n    (reset_n),
        .clear      ((state == IDLE) && setup),
        .increment  (cnt_inc),
        .expired    (expired)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            tgt_idx    <= 4'h0;
            tgt_mapped <= 1'b0;
        end else if (clk__enable) begin
            state <= next_state;
            if ((state == IDLE) && setup) begin
                tgt_idx    <= live_idx;
                tgt_mapped <= live_mapped;
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (setup) next_state = ACCESS;
            ACCESS:  if (!apb_request__psel || resp.pready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // A ready target beats a timeout that would fire in the same cycle.
    always_comb begin
        resp         = '0;
        sel_active   = 1'b0;
        sel_idx      = live_idx;
        timeout_fire = 1'b0;
        cnt_inc      = 1'b0;
        tgt_psel     = '0;
        case (state)
            IDLE: begin
                sel_idx    = live_idx;
                sel_active = apb_request__psel && live_mapped;
                if (apb_request__psel && apb_request__penable) resp = error_response();
            end
            ACCESS: begin
                sel_idx = tgt_idx;
                if (apb_request__psel) begin
                    if (!tgt_mapped) begin
                        resp = error_response();
                    end else if (rdy_arr[tgt_idx]) begin
                        sel_active  = 1'b1;
                        resp.prdata = rd_arr[tgt_idx];
                        resp.pready = 1'b1;
                        resp.perr   = err_arr[tgt_idx];
                    end else if (expired) begin
                        timeout_fire = 1'b1;
                        resp         = error_response();
                    end else begin
                        sel_active = 1'b1;
                        cnt_inc    = 1'b1;
                    end
                end
            end
            default: ;
        endcase
        for (int i = 0; i < NUM_TARGETS; i++) begin
            tgt_psel[i] = reset_n && sel_active && (sel_idx == 4'(i));
        end
    end

    assign err_done             = resp.pready && resp.perr;
    assign apb_response__prdata = resp.prdata;
    assign apb_response__pready = resp.pready;
    assign apb_response__perr   = resp.perr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            error_pulse   <= 1'b0;
            error_timeout <= 1'b0;
            error_addr    <= 32'h0;
        end else if (clk__enable) begin
            error_pulse <= err_done;
            if (err_done) begin
                error_timeout <= timeout_fire;
                error_addr    <= apb_request__paddr;
            end
        end
    end

endmodule

// File: tb/tb_apb_target_mux.sv
// Directed bench for apb_target_mux: a scoreboard queue holds the expected master response
// of each transfer, and immediate assertions compare it when pready returns.
module tb_apb_target_mux;

    localparam int NT  = 4;
    localparam int TMO = 8;

    typedef struct {
        logic [31:0] prdata;
        logic        perr;
        int          cycles;
    } exp_t;

    logic             clk = 1'b0;
    logic             clk__enable;
    logic             reset_n;
    logic [31:0]      paddr;
    logic             penable, psel, pwrite;
    logic [31:0]      pwdata;
    logic [31:0]      prdata;
    logic             pready, perr;
    logic [NT-1:0]    tgt_psel;
    logic [32*NT-1:0] tgt_prdata;
    logic [NT-1:0]    tgt_pready, tgt_perr;
    logic             error_pulse, error_timeout;
    logic [31:0]      error_addr;

    int          checks = 0;
    int          errors = 0;
    exp_t        exp_q[$];
    logic        last_err;
    logic        exp_timeout;
    logic [31:0] exp_addr;

    apb_target_mux #(
        .NUM_TARGETS(NT), .SEL_HI(31), .SEL_LO(28), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk                  (clk),
        .clk__enable          (clk__enable),
        .reset_n              (reset_n),
        .apb_request__paddr   (paddr),
        .apb_request__penable (penable),
        .apb_request__psel    (psel),
        .apb_request__pwrite  (pwrite),
        .apb_request__pwdata  (pwdata),
        .apb_response__prdata (prdata),
        .apb_response__pready (pready),
        .apb_response__perr   (perr),
        .tgt_psel             (tgt_psel),
        .tgt_prdata           (tgt_prdata),
        .tgt_pready           (tgt_pready),
        .tgt_perr             (tgt_perr),
        .error_pulse          (error_pulse),
        .error_timeout        (error_timeout),
        .error_addr           (error_addr)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] tgt_data(input int i);
        return (i == 1) ? 32'h1234_5678 : (32'hA5A5_0000 + 32'(i));
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full transfer; waits = access cycles the target holds pready low.
    task automatic do_transfer(input logic [31:0] addr, input logic wr, input int waits);
        int         idx;
        int         k;
        bit         done;
        exp_t       e;
        logic [3:0] exp_sel;
        idx = int'(addr[31:28]);
        if (idx >= NT)        e = '{32'h0, 1'b1, 1};
        else if (waits > TMO) e = '{32'h0, 1'b1, TMO + 1};
        else                  e = '{tgt_data(idx), 1'b0, waits + 1};
        exp_q.push_back(e);
        exp_sel = (idx < NT) ? 4'(1 << idx) : 4'h0;

        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; paddr = addr; pwrite = wr;
        pwdata = ~addr; tgt_pready = '0;
        @(negedge clk);
        check("setup_psel", 64'(tgt_psel), 64'(exp_sel));
        check("setup_pready", 64'(pready), 64'(0));

        k = 0;
        done = 1'b0;
        while (!done && k < TMO + 4) begin
            @(posedge clk); #1;
            k++;
            penable = 1'b1;
            tgt_pready = (idx < NT && k == waits + 1) ? 4'(1 << idx) : 4'h0;
            @(negedge clk);
            if (pready) begin
                done = 1'b1;
                e = exp_q.pop_front();
                check("prdata", 64'(prdata), 64'(e.prdata));
                check("perr", 64'(perr), 64'(e.perr));
                check("access_cycles", 64'(k), 64'(e.cycles));
                check("done_psel", 64'(tgt_psel), e.perr ? 64'(0) : 64'(exp_sel));
                last_err = e.perr;
                if (e.perr) begin
                    exp_timeout = (idx < NT);
                    exp_addr    = addr;
                end
            end else begin
                check("wait_psel", 64'(tgt_psel), 64'(exp_sel));
            end
        end
        check("completed", 64'(done), 64'(1));
        if (!done) void'(exp_q.pop_front());
    endtask

    task automatic idle_check_error();
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; tgt_pready = '0;
        @(negedge clk);
        check("error_pulse", 64'(error_pulse), 64'(last_err));
        check("error_timeout", 64'(error_timeout), 64'(exp_timeout));
        check("error_addr", 64'(error_addr), 64'(exp_addr));
        @(negedge clk);
        check("error_pulse_clear", 64'(error_pulse), 64'(0));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clk__enable = 1'b1;
        reset_n = 1'b0;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = 32'h0; pwdata = 32'h0;
        tgt_pready = '0; tgt_perr = '0;
        for (int i = 0; i < NT; i++) tgt_prdata[32*i +: 32] = tgt_data(i);
        last_err = 1'b0; exp_timeout = 1'b0; exp_addr = 32'h0;

        repeat (2) @(negedge clk);
        check("rst_error_pulse", 64'(error_pulse), 64'(0));
        check("rst_error_timeout", 64'(error_timeout), 64'(0));
        check("rst_error_addr", 64'(error_addr), 64'(0));
        check("rst_tgt_psel", 64'(tgt_psel), 64'(0));
        check("rst_pready", 64'(pready), 64'(0));
        @(posedge clk); #1;
        reset_n = 1'b1;

        do_transfer(32'h1000_0004, 1'b0, 0);
        idle_check_error();

        do_transfer(32'h2000_0008, 1'b0, 5);
        idle_check_error();

        do_transfer(32'h7000_0000, 1'b0, 0);
        idle_check_error();

        do_transfer(32'h0000_0040, 1'b0, 1000);
        idle_check_error();

        do_transfer(32'h0000_0044, 1'b0, TMO);
        idle_check_error();

        do_transfer(32'h3000_0008, 1'b1, 0);
        do_transfer(32'h0000_000C, 1'b0, 2);
        idle_check_error();

        // penable without a preceding setup phase
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b1; paddr = 32'h2000_0010;
        @(negedge clk);
        check("proto_pready", 64'(pready), 64'(1));
        check("proto_perr", 64'(perr), 64'(1));
        check("proto_prdata", 64'(prdata), 64'(0));
        last_err = 1'b1; exp_timeout = 1'b0; exp_addr = 32'h2000_0010;
        idle_check_error();

        // master drops psel mid-access
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; paddr = 32'h2000_0000;
        @(posedge clk); #1;
        penable = 1'b1;
        @(negedge clk);
        check("abort_wait_pready", 64'(pready), 64'(0));
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        @(negedge clk);
        check("abort_psel", 64'(tgt_psel), 64'(0));
        @(negedge clk);
        check("abort_no_error", 64'(error_pulse), 64'(0));
        last_err = 1'b0;
        do_transfer(32'h2000_0000, 1'b0, 2);
        idle_check_error();

        // async reset during a waited access
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; paddr = 32'h1000_0000;
        @(posedge clk); #1;
        penable = 1'b1;
        @(negedge clk);
        check("pre_reset_psel", 64'(tgt_psel), 64'(4'b0010));
        #1 reset_n = 1'b0;
        #1;
        check("in_reset_psel", 64'(tgt_psel), 64'(0));
        check("in_reset_error_addr", 64'(error_addr), 64'(0));
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        reset_n = 1'b1;
        last_err = 1'b0; exp_timeout = 1'b0; exp_addr = 32'h0;
        do_transfer(32'h1000_0004, 1'b0, 3);
        idle_check_error();

        check("scoreboard_empty", 64'(exp_q.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_target_mux.md
# apb_target_mux

Parametrised N-way APB address decoder and response multiplexer placed between a single APB master (e.g. apb_processor) and up to 16 APB targets (timer, gpio, uart, ...). It decodes a configurable field of paddr to a target index, latches that selection for the whole transfer, and muxes the selected target's response back. Unmapped accesses get an immediate error, and stalled targets get a timeout error. It replaces hand-written two-target decode logic in testbenches and top levels.

## Interface
- NUM_TARGETS, 4, number of targets; legal range 1..16
- SEL_HI, 31, top bit of the paddr select field
- SEL_LO, 28, bottom bit of the select field; field width SW = SEL_HI-SEL_LO+1, 2^SW >= NUM_TARGETS
- TIMEOUT_CYCLES, 256, maximum wait cycles before a timeout error; 0 disables the timeout
- clk  in  1  clock, all state on rising edge
- clk__enable  in  1  qualifies every register update
- reset_n  in  1  reset; asynchronous, active-low
- apb_request__paddr / __penable / __psel / __pwrite / __pwdata  in  32/1/1/1/32  master request
- apb_response__prdata / __pready / __perr  out  32/1/1  response to the master
- tgt_psel  out  NUM_TARGETS  per-target psel; paddr, penable, pwrite and pwdata are broadcast to all targets outside this block
- tgt_prdata / tgt_pready / tgt_perr  in  32*NUM_TARGETS / NUM_TARGETS / NUM_TARGETS  target responses; target i uses slice i
- error_pulse  out  1  one-cycle registered pulse after any error completion
- error_timeout  out  1  cause of the last error: 1 = timeout, 0 = unmapped or protocol
- error_addr  out  32  paddr of the last errored transfer (sticky)

## Operation
- Registers: state {IDLE, ACCESS}, tgt_idx[3:0], tgt_mapped, wait_cnt, plus the error outputs.
- Decode: idx = paddr[SEL_HI:SEL_LO]. The address is mapped iff idx < NUM_TARGETS.
- IDLE:
  - tgt_psel[idx] = psel && mapped, decoded from the live paddr.
  - On psel && !penable (setup phase): latch tgt_idx and tgt_mapped, clear wait_cnt, and go to ACCESS.
- ACCESS:
  - tgt_psel[tgt_idx] = psel && tgt_mapped. The latched index is used even if paddr changes.
  - If mapped and the target is ready, the response is the target's prdata/pready/perr.
  - If mapped, the target is not ready, and wait_cnt == TIMEOUT_CYCLES != 0: return pready=1, perr=1, prdata=0, and deassert tgt_psel that cycle.
  - If mapped, the target is not ready, and no timeout: pready=0, and wait_cnt increments.
  - If unmapped: pready=1, perr=1, prdata=0 in the first access cycle (zero wait).
  - When master pready=1, return to IDLE.
- Protocol violation (psel && penable while in IDLE): respond pready=1, perr=1, prdata=0. This counts as an unmapped error and the state stays IDLE.
- Master response is 0 with pready=0 whenever psel=0, and during the setup phase.
- Error recording: on any error completion, the next edge sets error_pulse=1 for one cycle, updates error_timeout, and captures error_addr.

## Timing
- Reset values: state IDLE, wait_cnt 0, tgt_idx 0, error_pulse 0, error_timeout 0, error_addr 0. tgt_psel follows psel combinationally.
- Request to target and response to master are purely combinational, adding zero cycles of latency.
- A mapped transfer to a target with N wait states completes in 2+N cycles (setup plus access), exactly as with a direct connection.
- Timeout: the error is returned on access cycle TIMEOUT_CYCLES+1, so the maximum transfer length is TIMEOUT_CYCLES+2 cycles. wait_cnt is clog2(TIMEOUT_CYCLES+1) bits wide and saturates.
- If the target asserts pready in the same cycle the timeout would fire, the target response wins and no error is recorded.
- Back-to-back transfers: the setup phase immediately following an ACCESS completion is accepted in IDLE with no idle gap.
- psel dropping mid-ACCESS (protocol abort): return to IDLE next edge with no error recorded.
- Asynchronous reset mid-transfer: the block immediately returns to IDLE and all tgt_psel outputs go low while reset_n=0.

## Structure
- Package apb_target_mux_pkg holds the state enum (IDLE, ACCESS) and the APB request/response struct typedefs shared with apb_processor and the targets.
- One sub-module: apb_timeout_counter. It holds the saturating wait counter with clear, increment and expired outputs, parametrised on TIMEOUT_CYCLES.
- Decode and response mux stay in the top module as generate-indexed combinational logic.

## Test plan
- Default params, reads to paddr 0x1000_0004 (target 1, zero wait, prdata=0x1234_5678): tgt_psel=4'b0010, master prdata=0x1234_5678, completes in 2 cycles, no error_pulse.
- Target 2 with 5 wait states: master pready=0 for 5 access cycles, then data with perr=0, for 7 cycles total.
- Access to 0x7000_0000 (unmapped, idx 7): no tgt_psel asserted; pready=1, perr=1, prdata=0 in the first access cycle; error_pulse one cycle later; error_timeout=0; error_addr=0x7000_0000.
- TIMEOUT_CYCLES=8 with target 0 never ready: perr=1 on access cycle 9 and tgt_psel[0] drops that cycle, error_timeout=1. Repeat with target pready raised on exactly that cycle: target data returned, no error.
- Back-to-back write then read to targets 3 and 0: each latches its own index, and no idle cycle is inserted.
- reset_n pulsed low during a waited access to target 1: tgt_psel goes 0 immediately, state returns to IDLE, and the next transfer completes normally.
